// File: rtl/div_unit_rn.sv
// rtl/div_unit_rn.sv - iterative restoring integer divider (DIV/DIVU/REM/REMU) with operand-reuse fast path
//
// Parameters
//   XLEN            operand/result width (32 or 64)
//   BITS_PER_CYCLE  quotient bits retired per CALC cycle (1, 2 or 4)
//   REUSE_EN        1 enables the last-op reuse fast path
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   start_i         request to begin an operation (qualified by valid_i)
//   flush_i         abort any operation in progress, invalidate reuse entry
//   valid_i         qualifies start_i
//   funct3_i        100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_i, rs2_i    dividend, divisor
//   rd_i            destination tag
//   ready_o         one-cycle result-valid pulse (state DONE)
//   busy_o          iteration in progress (state CALC)
//   rd_o, result_o  tag and result of the last completed op
module div_unit_rn #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit REUSE_EN       = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] result_o
);

    localparam int K  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(K);
    localparam logic [CW-1:0]   K_LAST  = CW'(K - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t state_q, state_d;

    // Captured op
    logic [4:0]      rd_q;
    logic            is_rem_q;
    logic            sgn_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;

    // Iteration state: a_q shifts dividend out / quotient in, r_q is the partial remainder
    logic [XLEN-1:0] a_q;
    logic [XLEN:0]   r_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   cnt_q;

    // Reuse entry
    logic            ru_vld_q;
    logic [XLEN-1:0] ru_a_q;
    logic [XLEN-1:0] ru_b_q;
    logic            ru_s_q;
    logic [XLEN-1:0] ru_quo_q;
    logic [XLEN-1:0] ru_rem_q;

    logic [4:0]      rd_o_q;
    logic [XLEN-1:0] result_q;

    // Acceptance and fast-path detection
    logic            accept;
    logic            signed_op;
    logic            div0;
    logic            ovf;
    logic            reuse_hit;
    logic            fast;
    logic            last_step;
    logic [XLEN-1:0] fast_res;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign signed_op = ~funct3_i[0];
    assign accept    = start_i & valid_i & funct3_i[2] & ~flush_i & (state_q != S_CALC);
    assign div0      = (rs2_i == '0);
    assign ovf       = signed_op & (rs1_i == MOST_NEG) & (rs2_i == '1);
    assign reuse_hit = REUSE_EN & ru_vld_q & (ru_a_q == rs1_i) & (ru_b_q == rs2_i)
                     & (ru_s_q == signed_op);
    assign fast      = div0 | ovf | reuse_hit;
    assign last_step = (state_q == S_CALC) && (cnt_q == K_LAST);
    assign mag_a     = (signed_op && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign mag_b     = (signed_op && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = funct3_i[1] ? rs1_i : '1;
        else if (ovf)
            fast_res = funct3_i[1] ? '0 : MOST_NEG;
        else
            fast_res = funct3_i[1] ? ru_rem_q : ru_quo_q;
    end

    // BITS_PER_CYCLE restoring steps per clock
    logic [XLEN-1:0] a_t;
    logic [XLEN:0]   r_t;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;

    always_comb begin
        a_t = a_q;
        r_t = r_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r_t = {r_t[XLEN-1:0], a_t[XLEN-1]};
            a_t = {a_t[XLEN-2:0], 1'b0};
            if (r_t >= {1'b0, b_q}) begin
                r_t    = r_t - {1'b0, b_q};
                a_t[0] = 1'b1;
            end
        end
    end

    assign quo_fin = neg_quo_q ? -a_t : a_t;
    assign rem_fin = neg_rem_q ? -r_t[XLEN-1:0] : r_t[XLEN-1:0];

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
                S_CALC:  if (last_step) state_d = S_DONE;
                S_DONE:  state_d = accept ? (fast ? S_DONE : S_CALC) : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        ready_o = (state_q == S_DONE);
        busy_o  = (state_q == S_CALC);
    end

    assign rd_o     = rd_o_q;
    assign result_o = result_q;

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            a_q       <= '0;
            r_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            ru_vld_q  <= 1'b0;
            ru_a_q    <= '0;
            ru_b_q    <= '0;
            ru_s_q    <= 1'b0;
            ru_quo_q  <= '0;
            ru_rem_q  <= '0;
            rd_o_q    <= '0;
            result_q  <= '0;
        end else if (flush_i) begin
            ru_vld_q <= 1'b0;
        end else if (accept) begin
            rd_q      <= rd_i;
            is_rem_q  <= funct3_i[1];
            sgn_q     <= signed_op;
            neg_quo_q <= signed_op & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_rem_q <= signed_op & rs1_i[XLEN-1];
            op_a_q    <= rs1_i;
            op_b_q    <= rs2_i;
            a_q       <= mag_a;
            r_q       <= '0;
            b_q       <= mag_b;
            cnt_q     <= '0;
            // Fast ops enter DONE on this very edge
            if (fast) begin
                result_q <= fast_res;
                rd_o_q   <= rd_i;
            end
        end else if (state_q == S_CALC) begin
            a_q   <= a_t;
            r_q   <= r_t;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
                result_q <= is_rem_q ? rem_fin : quo_fin;
                rd_o_q   <= rd_q;
                if (REUSE_EN) begin
                    ru_vld_q <= 1'b1;
                    ru_a_q   <= op_a_q;
                    ru_b_q   <= op_b_q;
                    ru_s_q   <= sgn_q;
                    ru_quo_q <= quo_fin;
                    ru_rem_q <= rem_fin;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit_rn.sv
// tb/tb_div_unit_rn.sv - directed self-checking bench for div_unit_rn
module tb_div_unit_rn;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0;
    logic        start4 = 1'b0;
    logic        start64 = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic [4:0]  rd_in = '0;

    logic        rdy32, bsy32, rdy4, bsy4, rdy64, bsy64;
    logic [4:0]  rdo32, rdo4, rdo64;
    logic [31:0] res32, res4;
    logic [63:0] res64;

    int nvec = 0;
    int nerr = 0;
    int lat;
    int bcnt;
    int seen;

    always #5 clk = ~clk;

    div_unit_rn #(.XLEN(32), .BITS_PER_CYCLE(1), .REUSE_EN(1'b1)) u_d32 (
        .clk(clk), .reset_n(reset_n), .start_i(start32), .flush_i(flush), .valid_i(valid),
        .funct3_i(funct3), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_i(rd_in),
        .ready_o(rdy32), .busy_o(bsy32), .rd_o(rdo32), .result_o(res32));

    div_unit_rn #(.XLEN(32), .BITS_PER_CYCLE(4), .REUSE_EN(1'b1)) u_d4 (
        .clk(clk), .reset_n(reset_n), .start_i(start4), .flush_i(flush), .valid_i(valid),
        .funct3_i(funct3), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_i(rd_in),
        .ready_o(rdy4), .busy_o(bsy4), .rd_o(rdo4), .result_o(res4));

    div_unit_rn #(.XLEN(64), .BITS_PER_CYCLE(1), .REUSE_EN(1'b1)) u_d64 (
        .clk(clk), .reset_n(reset_n), .start_i(start64), .flush_i(flush), .valid_i(valid),
        .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd_in),
        .ready_o(rdy64), .busy_o(bsy64), .rd_o(rdo64), .result_o(res64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one op on the selected DUT, then counts cycles until ready_o (bounded).
    // at_neg=1 means the caller is already at a negedge (back-to-back issue from DONE).
    task automatic run_op(input int dut, input bit at_neg, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input int budget, output int latency, output int busy_cycles);
        if (!at_neg) @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; valid = 1'b1;
        case (dut)
            0: start32 = 1'b1;
            1: start4  = 1'b1;
            default: start64 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start32 = 1'b0; start4 = 1'b0; start64 = 1'b0; valid = 1'b0;
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        rd_in = 5'($urandom);
        latency = -1;
        busy_cycles = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if ((dut == 0 && bsy32) || (dut == 1 && bsy4) || (dut == 2 && bsy64))
                busy_cycles++;
            if ((dut == 0 && rdy32) || (dut == 1 && rdy4) || (dut == 2 && rdy64)) begin
                latency = n;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", {63'd0, rdy32}, 64'd0);
        chk("rst_busy", {63'd0, bsy32}, 64'd0);
        chk("rst_rd", {59'd0, rdo32}, 64'd0);
        chk("rst_result", {32'd0, res32}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // DIV -40/8, first accept right after reset release
        run_op(0, 1'b0, 3'b100, 64'hFFFFFFD8, 64'd8, 5'd10, 100, lat, bcnt);
        chk("div_neg_res", {32'd0, res32}, 64'hFFFFFFFB);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_busy", 64'(bcnt), 64'd32);
        chk("div_neg_rd", {59'd0, rdo32}, 64'd10);
        @(negedge clk);
        chk("ready_pulse_1cyc", {63'd0, rdy32}, 64'd0);

        // Divide by zero
        run_op(0, 1'b0, 3'b100, 64'd123, 64'd0, 5'd3, 100, lat, bcnt);
        chk("div0_res", {32'd0, res32}, 64'hFFFFFFFF);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_busy", 64'(bcnt), 64'd0);
        run_op(0, 1'b0, 3'b111, 64'd123, 64'd0, 5'd4, 100, lat, bcnt);
        chk("remu0_res", {32'd0, res32}, 64'd123);
        chk("remu0_lat", 64'(lat), 64'd1);
        chk("remu0_busy", 64'(bcnt), 64'd0);
        chk("remu0_rd", {59'd0, rdo32}, 64'd4);

        // Signed overflow
        run_op(0, 1'b0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd5, 100, lat, bcnt);
        chk("ovf_div_res", {32'd0, res32}, 64'h80000000);
        chk("ovf_div_lat", 64'(lat), 64'd1);
        run_op(0, 1'b0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd6, 100, lat, bcnt);
        chk("ovf_rem_res", {32'd0, res32}, 64'd0);
        chk("ovf_rem_lat", 64'(lat), 64'd1);

        // Reuse: DIV then REM on same operands, flush invalidates
        run_op(0, 1'b0, 3'b100, 64'hFFFFFFD8, 64'd6, 5'd7, 100, lat, bcnt);
        chk("div_m40_6_res", {32'd0, res32}, 64'hFFFFFFFA);
        chk("div_m40_6_lat", 64'(lat), 64'd33);
        run_op(0, 1'b0, 3'b110, 64'hFFFFFFD8, 64'd6, 5'd8, 100, lat, bcnt);
        chk("rem_reuse_res", {32'd0, res32}, 64'hFFFFFFFC);
        chk("rem_reuse_lat", 64'(lat), 64'd1);
        chk("rem_reuse_rd", {59'd0, rdo32}, 64'd8);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op(0, 1'b0, 3'b110, 64'hFFFFFFD8, 64'd6, 5'd9, 100, lat, bcnt);
        chk("rem_noreuse_res", {32'd0, res32}, 64'hFFFFFFFC);
        chk("rem_noreuse_lat", 64'(lat), 64'd33);

        // Back-to-back: new ops accepted while in DONE
        run_op(0, 1'b0, 3'b101, 64'd100, 64'd7, 5'd11, 100, lat, bcnt);
        chk("divu_100_7_res", {32'd0, res32}, 64'd14);
        chk("divu_100_7_lat", 64'(lat), 64'd33);
        run_op(0, 1'b1, 3'b101, 64'd100, 64'd7, 5'd12, 100, lat, bcnt);
        chk("b2b_divu_res", {32'd0, res32}, 64'd14);
        chk("b2b_divu_lat", 64'(lat), 64'd1);
        chk("b2b_divu_rd", {59'd0, rdo32}, 64'd12);
        run_op(0, 1'b1, 3'b111, 64'd100, 64'd7, 5'd13, 100, lat, bcnt);
        chk("b2b_remu_res", {32'd0, res32}, 64'd2);
        chk("b2b_remu_lat", 64'(lat), 64'd1);

        // Flush at CALC cycle 10
        @(negedge clk);
        funct3 = 3'b101; rs1 = 64'd1000; rs2 = 64'd7; rd_in = 5'd14; valid = 1'b1; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, bsy32}, 64'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy32) seen++;
        end
        chk("flush_no_ready", 64'(seen), 64'd0);
        chk("flush_result_hold", {32'd0, res32}, 64'd2);
        chk("flush_rd_hold", {59'd0, rdo32}, 64'd13);
        run_op(0, 1'b0, 3'b101, 64'd40, 64'd8, 5'd15, 100, lat, bcnt);
        chk("post_flush_res", {32'd0, res32}, 64'd5);
        chk("post_flush_lat", 64'(lat), 64'd33);

        // Reset mid-CALC
        @(negedge clk);
        funct3 = 3'b101; rs1 = 64'd999; rs2 = 64'd5; rd_in = 5'd16; valid = 1'b1; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, bsy32}, 64'd0);
        chk("async_rst_result", {32'd0, res32}, 64'd0);
        chk("async_rst_rd", {59'd0, rdo32}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdy32 || bsy32) seen++;
        end
        chk("rst_discard", 64'(seen), 64'd0);

        // BITS_PER_CYCLE=4
        run_op(1, 1'b0, 3'b111, 64'hFFFFFFFF, 64'hFE98F000, 5'd17, 100, lat, bcnt);
        chk("bpc4_remu_res", {32'd0, res4}, 64'h01670FFF);
        chk("bpc4_remu_lat", 64'(lat), 64'd9);
        chk("bpc4_remu_busy", 64'(bcnt), 64'd8);

        // XLEN=64
        run_op(2, 1'b0, 3'b100, 64'd0, 64'hFFFFFFFFFFFFFFFF, 5'd18, 200, lat, bcnt);
        chk("x64_div_res", res64, 64'd0);
        chk("x64_div_lat", 64'(lat), 64'd65);
        chk("x64_div_rd", {59'd0, rdo64}, 64'd18);
        run_op(2, 1'b0, 3'b110, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd19, 200, lat, bcnt);
        chk("x64_rem_res", res64, 64'hFFFFFFFFFFFFFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
